qsfp_xcvr_reset_seq: RTL and testbench

QSFP_XCVR_RESET_SEQ -- requirements
Module: qsfp_xcvr_reset_seq

---
 rtl/qsfp_xcvr_rst_pkg.sv | 28 ++
 rtl/qsfp_xcvr_sync_bit.sv | 21 ++
 rtl/qsfp_xcvr_reset_seq.sv | 182 ++++++++++++++++++
 tb/tb_qsfp_xcvr_reset_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/qsfp_xcvr_rst_pkg.sv
// rtl/qsfp_xcvr_rst_pkg.sv - State encoding and counter sizing for the QSFP transceiver reset sequencer.
package qsfp_xcvr_rst_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    PLL_PD      = 3'd0,
    WAIT_LOCK   = 3'd1,
    TX_DIG_WAIT = 3'd2,
    RX_LTD_WAIT = 3'd3,
    READY       = 3'd4
  } rst_state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // One extra bit of headroom so the largest terminal count never sits on the saturation value.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    return $clog2(max4(a, b, c, d)) + 1;
  endfunction

endpackage

// File: rtl/qsfp_xcvr_sync_bit.sv
// rtl/qsfp_xcvr_sync_bit.sv - Two-flop single-bit synchronizer with synchronous active-low clear.
module qsfp_xcvr_sync_bit (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/qsfp_xcvr_reset_seq.sv
// rtl/qsfp_xcvr_reset_seq.sv - QSFP transceiver PLL/TX/RX reset sequencer.
// Optional lock watchdog enabled by defining QSFP_XCVR_RESET_SEQ_TIMEOUT_EN.
import qsfp_xcvr_rst_pkg::*;

module qsfp_xcvr_reset_seq #(
  parameter int PLL_PD_CYCLES       = 1000,
  parameter int TX_DIG_CYCLES       = 20,
  parameter int LTD_CYCLES          = 500,
  parameter int LOCK_TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pll_locked,
  input  logic cal_busy,
  input  logic rx_is_lockedtodata,
  output logic pll_powerdown,
  output logic tx_analogreset,
  output logic tx_digitalreset,
  output logic rx_analogreset,
  output logic rx_digitalreset,
  output logic tx_ready,
  output logic rx_ready,
  output logic lock_timeout
);

  localparam int CW = cnt_width(PLL_PD_CYCLES, TX_DIG_CYCLES, LTD_CYCLES, LOCK_TIMEOUT_CYCLES);
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t PD_LAST  = cnt_t'(PLL_PD_CYCLES - 1);
  localparam cnt_t TX_LAST  = cnt_t'(TX_DIG_CYCLES - 1);
  localparam cnt_t LTD_LAST = cnt_t'(LTD_CYCLES - 1);
`ifdef QSFP_XCVR_RESET_SEQ_TIMEOUT_EN
  localparam cnt_t TO_LAST  = cnt_t'(LOCK_TIMEOUT_CYCLES - 1);
`endif

  function automatic cnt_t sat_inc(input cnt_t c);
    return (&c) ? c : c + cnt_t'(1);
  endfunction

  logic lock_s, cal_s, ltd_s;

  qsfp_xcvr_sync_bit u_sync_lock (.clk(clk), .reset_n(reset_n), .d(pll_locked),         .q(lock_s));
  qsfp_xcvr_sync_bit u_sync_cal  (.clk(clk), .reset_n(reset_n), .d(cal_busy),           .q(cal_s));
  qsfp_xcvr_sync_bit u_sync_ltd  (.clk(clk), .reset_n(reset_n), .d(rx_is_lockedtodata), .q(ltd_s));

  rst_state_e state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic pd_q, ta_q, td_q, ra_q, rd_q, tr_q, rr_q;
  logic pd_d, ta_d, td_d, ra_d, rd_d, tr_d, rr_d;
`ifdef QSFP_XCVR_RESET_SEQ_TIMEOUT_EN
  logic lt_q, lt_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = sat_inc(cnt_q);
    pd_d    = pd_q;
    ta_d    = ta_q;
    td_d    = td_q;
    ra_d    = ra_q;
    rd_d    = rd_q;
    tr_d    = tr_q;
    rr_d    = rr_q;
`ifdef QSFP_XCVR_RESET_SEQ_TIMEOUT_EN
    lt_d    = lt_q;
`endif
    case (state_q)
      PLL_PD: begin
        if (cnt_q == PD_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          pd_d    = 1'b0;
        end
      end
      WAIT_LOCK: begin
        if (lock_s && !cal_s) begin
          state_d = TX_DIG_WAIT;
          cnt_d   = '0;
          ta_d    = 1'b0;
        end
`ifdef QSFP_XCVR_RESET_SEQ_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d = PLL_PD;
          cnt_d   = '0;
          pd_d    = 1'b1;
          lt_d    = 1'b1;
        end
`endif
      end
      TX_DIG_WAIT, RX_LTD_WAIT, READY: begin
        // Loss of PLL lock outranks any RX-side event in these states.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          pd_d    = 1'b0;
          ta_d    = 1'b1;
          td_d    = 1'b1;
          ra_d    = 1'b1;
          rd_d    = 1'b1;
          tr_d    = 1'b0;
          rr_d    = 1'b0;
        end else if (state_q == TX_DIG_WAIT) begin
          if (cnt_q == TX_LAST) begin
            state_d = RX_LTD_WAIT;
            cnt_d   = '0;
            td_d    = 1'b0;
            tr_d    = 1'b1;
            ra_d    = 1'b0;
          end
        end else if (state_q == RX_LTD_WAIT) begin
          if (!ltd_s) begin
            cnt_d = '0;
          end else if (cnt_q == LTD_LAST) begin
            state_d = READY;
            cnt_d   = '0;
            rd_d    = 1'b0;
            rr_d    = 1'b1;
          end
        end else if (!ltd_s) begin
          state_d = RX_LTD_WAIT;
          cnt_d   = '0;
          rd_d    = 1'b1;
          rr_d    = 1'b0;
        end
      end
      default: begin
        state_d = PLL_PD;
        cnt_d   = '0;
        pd_d    = 1'b1;
        ta_d    = 1'b1;
        td_d    = 1'b1;
        ra_d    = 1'b1;
        rd_d    = 1'b1;
        tr_d    = 1'b0;
        rr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= PLL_PD;
      cnt_q   <= '0;
      pd_q    <= 1'b1;
      ta_q    <= 1'b1;
      td_q    <= 1'b1;
      ra_q    <= 1'b1;
      rd_q    <= 1'b1;
      tr_q    <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pd_q    <= pd_d;
      ta_q    <= ta_d;
      td_q    <= td_d;
      ra_q    <= ra_d;
      rd_q    <= rd_d;
      tr_q    <= tr_d;
      rr_q    <= rr_d;
    end
  end

`ifdef QSFP_XCVR_RESET_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) lt_q <= 1'b0;
    else          lt_q <= lt_d;
  end
  assign lock_timeout = lt_q;
`else
  assign lock_timeout = 1'b0;
`endif

  assign pll_powerdown   = pd_q;
  assign tx_analogreset  = ta_q;
  assign tx_digitalreset = td_q;
  assign rx_analogreset  = ra_q;
  assign rx_digitalreset = rd_q;
  assign tx_ready        = tr_q;
  assign rx_ready        = rr_q;

endmodule

// File: tb/tb_qsfp_xcvr_reset_seq.sv
// tb/tb_qsfp_xcvr_reset_seq.sv - Self-checking bench for qsfp_xcvr_reset_seq.
module tb_qsfp_xcvr_reset_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic pll_locked = 1'b0;
  logic cal_busy = 1'b0;
  logic rx_is_lockedtodata = 1'b0;
  logic pll_powerdown, tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset;
  logic tx_ready, rx_ready, lock_timeout;

  always #5 clk = ~clk;

  qsfp_xcvr_reset_seq #(
    .PLL_PD_CYCLES(8),
    .TX_DIG_CYCLES(4),
    .LTD_CYCLES(4),
    .LOCK_TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .pll_locked(pll_locked),
    .cal_busy(cal_busy),
    .rx_is_lockedtodata(rx_is_lockedtodata),
    .pll_powerdown(pll_powerdown),
    .tx_analogreset(tx_analogreset),
    .tx_digitalreset(tx_digitalreset),
    .rx_analogreset(rx_analogreset),
    .rx_digitalreset(rx_digitalreset),
    .tx_ready(tx_ready),
    .rx_ready(rx_ready),
    .lock_timeout(lock_timeout)
  );

  // {pll_powerdown, tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset, tx_ready, rx_ready, lock_timeout}
  logic [7:0] outs;
  assign outs = {pll_powerdown, tx_analogreset, tx_digitalreset, rx_analogreset,
                 rx_digitalreset, tx_ready, rx_ready, lock_timeout};

  localparam logic [7:0] O_RST = 8'b11111000;
  localparam logic [7:0] O_WL  = 8'b01111000;
  localparam logic [7:0] O_TXD = 8'b00111000;
  localparam logic [7:0] O_RXL = 8'b00001100;
  localparam logic [7:0] O_RDY = 8'b00000110;

  typedef struct {
    bit         rstn;
    bit         pl;
    bit         cb;
    bit         ltd;
    int         n;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] sb_exp[$];
  string      sb_name[$];
  int         n_checks = 0;
  int         n_fail = 0;

  function automatic vec_t mk(input bit r, input bit pl, input bit cb, input bit ltd,
                              input int n, input logic [7:0] e, input string nm);
    vec_t v;
    v.rstn = r; v.pl = pl; v.cb = cb; v.ltd = ltd; v.n = n; v.exp = e; v.name = nm;
    return v;
  endfunction

  task automatic check_out();
    logic [7:0] e;
    string      nm;
    e  = sb_exp.pop_front();
    nm = sb_name.pop_front();
    n_checks++;
    if (outs !== e) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, outs, e);
    end
  endtask

  // Entered and left at a falling edge: drive, let n rising edges pass, compare.
  task automatic apply(input vec_t v);
    reset_n            = v.rstn;
    pll_locked         = v.pl;
    cal_busy           = v.cb;
    rx_is_lockedtodata = v.ltd;
    sb_exp.push_back(v.exp);
    sb_name.push_back(v.name);
    repeat (v.n) @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  task automatic run_table();
    foreach (tbl[i]) apply(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    @(negedge clk);

    // Power-up sequence, then a one-cycle PLL glitch in READY and full relock.
    tbl.push_back(mk(0, 1, 0, 1, 3, O_RST, "reset_state"));
    tbl.push_back(mk(1, 1, 0, 1, 7, O_RST, "pd_held"));
    tbl.push_back(mk(1, 1, 0, 1, 1, O_WL,  "pd_release"));
    tbl.push_back(mk(1, 1, 0, 1, 1, O_TXD, "tx_analog_rel"));
    tbl.push_back(mk(1, 1, 0, 1, 3, O_TXD, "tx_dig_hold"));
    tbl.push_back(mk(1, 1, 0, 1, 1, O_RXL, "tx_ready"));
    tbl.push_back(mk(1, 1, 0, 1, 3, O_RXL, "rx_ltd_hold"));
    tbl.push_back(mk(1, 1, 0, 1, 1, O_RDY, "rx_ready"));
    tbl.push_back(mk(1, 0, 0, 1, 1, O_RDY, "glitch_sync1"));
    tbl.push_back(mk(1, 1, 0, 1, 1, O_RDY, "glitch_sync2"));
    tbl.push_back(mk(1, 1, 0, 1, 1, O_WL,  "glitch_reset"));
    tbl.push_back(mk(1, 1, 0, 1, 1, O_TXD, "relock_tx_analog"));
    tbl.push_back(mk(1, 1, 0, 1, 3, O_TXD, "relock_tx_hold"));
    tbl.push_back(mk(1, 1, 0, 1, 1, O_RXL, "relock_tx_ready"));
    tbl.push_back(mk(1, 1, 0, 1, 3, O_RXL, "relock_rx_hold"));
    tbl.push_back(mk(1, 1, 0, 1, 1, O_RDY, "relock_rx_ready"));
    tbl.push_back(mk(1, 1, 0, 0, 2, O_RDY, "ltd_drop_sync"));
    tbl.push_back(mk(1, 1, 0, 0, 1, O_RXL, "ltd_drop"));
    run_table();

    // Toggling lock-to-data never reaches four consecutive synced highs.
    for (int k = 0; k < 2; k++) begin
      apply(mk(1, 1, 0, 1, 3, O_RXL, "ltd_toggle_hi"));
      apply(mk(1, 1, 0, 0, 3, O_RXL, "ltd_toggle_lo"));
    end
    apply(mk(1, 1, 0, 1, 5, O_RXL, "ltd_stable_hold"));
    apply(mk(1, 1, 0, 1, 1, O_RDY, "ltd_stable_rel"));

    // Calibration busy gating, then a reset in TX_DIG_WAIT and restart.
    tbl.push_back(mk(0, 1, 1, 1, 2, O_RST, "reset_cal"));
    tbl.push_back(mk(1, 1, 1, 1, 8, O_WL,  "pd_done_cal"));
    tbl.push_back(mk(1, 1, 1, 1, 6, O_WL,  "cal_busy_hold"));
    tbl.push_back(mk(1, 1, 0, 1, 2, O_WL,  "cal_fall_sync"));
    tbl.push_back(mk(1, 1, 0, 1, 1, O_TXD, "cal_fall_tx"));
    tbl.push_back(mk(1, 1, 0, 1, 2, O_TXD, "tx_dig_mid"));
    tbl.push_back(mk(0, 1, 0, 1, 1, O_RST, "reset_mid_tx"));
    tbl.push_back(mk(1, 1, 0, 1, 8, O_WL,  "restart_pd"));
    tbl.push_back(mk(1, 1, 0, 1, 1, O_TXD, "restart_tx"));
    tbl.push_back(mk(1, 0, 0, 1, 3, O_WL,  "lock_loss_tx"));
`ifdef QSFP_XCVR_RESET_SEQ_TIMEOUT_EN
    tbl.push_back(mk(1, 0, 0, 1, 63, O_WL,         "wl_before_timeout"));
    tbl.push_back(mk(1, 0, 0, 1, 1,  8'b11111001,  "timeout_pd"));
    tbl.push_back(mk(1, 0, 0, 1, 7,  8'b11111001,  "timeout_pd_hold"));
    tbl.push_back(mk(1, 0, 0, 1, 1,  8'b01111001,  "timeout_pd_rel"));
    tbl.push_back(mk(1, 0, 0, 1, 40, 8'b01111001,  "timeout_sticky"));
`else
    tbl.push_back(mk(1, 0, 0, 1, 150, O_WL, "no_watchdog"));
`endif
    run_table();

    if (sb_exp.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_exp.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
